// File: rtl/ascii_pos_pkg.sv
// Shared constants and types for the streaming ASCII-to-alphabet-position encoder.
package ascii_pos_pkg;

    localparam logic [6:0] ASCII_UA = 7'h41;
    localparam logic [6:0] ASCII_UZ = 7'h5A;
    localparam logic [6:0] ASCII_LA = 7'h61;
    localparam logic [6:0] ASCII_LZ = 7'h7A;
    localparam int         POS_W    = 5;

    typedef enum logic {
        GAP     = 1'b0,
        IN_WORD = 1'b1
    } word_state_t;

    typedef struct packed {
        logic             upper;
        logic [POS_W-1:0] pos;
    } fifo_entry_t;

endpackage

// File: rtl/ascii_pos_stream_if.sv
// Character-in / position-out handshake bundle; master is the source+sink, slave is the encoder.
interface ascii_pos_stream_if;
    import ascii_pos_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_ascii;
    logic             fold;
    logic             out_valid;
    logic             out_ready;
    logic [POS_W-1:0] out_pos;
    logic             out_upper;

    modport master (
        output in_valid, in_ascii, fold, out_ready,
        input  in_ready, out_valid, out_pos, out_upper
    );

    modport slave (
        input  in_valid, in_ascii, fold, out_ready,
        output in_ready, out_valid, out_pos, out_upper
    );

endinterface

// File: rtl/ascii_pos_enc.sv
// Combinational ASCII -> alphabet position encoder (1..26, 0 for anything that is not a letter).
module ascii_pos_enc
    import ascii_pos_pkg::*;
(
    input  logic [6:0]       ascii,
    input  logic             fold,
    output logic [POS_W-1:0] pos,
    output logic             upper,
    output logic             is_letter
);

    always_comb begin
        pos   = '0;
        upper = 1'b0;
        // Inside either letter range the low five code bits already equal the position.
        if (ascii >= ASCII_UA && ascii <= ASCII_UZ) begin
            pos   = ascii[POS_W-1:0];
            upper = 1'b1;
        end else if (fold && ascii >= ASCII_LA && ascii <= ASCII_LZ) begin
            pos   = ascii[POS_W-1:0];
        end
    end

    assign is_letter = (pos != '0);

endmodule

// File: rtl/ascii_pos_stream.sv
// Streaming encoder: handshake in, FIFO-buffered positions out, saturating letter/other/word counters.
module ascii_pos_stream
    import ascii_pos_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    ascii_pos_stream_if.slave  bus,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   letter_cnt,
    output logic [CNT_W-1:0]   other_cnt,
    output logic [CNT_W-1:0]   word_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    fifo_entry_t      mem [DEPTH];
    fifo_entry_t      enc_entry, head;
    logic             enc_letter;
    logic             full, empty, push, pop;
    word_state_t      state_reg, state_next;
    logic             word_inc;
    logic [CNT_W-1:0] letter_cnt_reg, other_cnt_reg, word_cnt_reg;

    ascii_pos_enc u_enc (
        .ascii     (bus.in_ascii),
        .fold      (bus.fold),
        .pos       (enc_entry.pos),
        .upper     (enc_entry.upper),
        .is_letter (enc_letter)
    );

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign bus.in_ready  = !full && !rst;
    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign head          = mem[rd_ptr_reg[AW-1:0]];
    assign bus.out_pos   = empty ? '0 : head.pos;
    assign bus.out_upper = !empty && head.upper;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= enc_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= GAP;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        word_inc   = 1'b0;
        if (clr_cnt) begin
            state_next = GAP;
        end else if (push) begin
            case (state_reg)
                GAP: if (enc_letter) begin
                    state_next = IN_WORD;
                    word_inc   = 1'b1;
                end
                IN_WORD: if (!enc_letter) state_next = GAP;
                default: state_next = GAP;
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Clear has priority, so a character accepted in the clearing cycle is never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            letter_cnt_reg <= '0;
            other_cnt_reg  <= '0;
            word_cnt_reg   <= '0;
        end else if (clr_cnt) begin
            letter_cnt_reg <= '0;
            other_cnt_reg  <= '0;
            word_cnt_reg   <= '0;
        end else if (push) begin
            if (enc_letter) letter_cnt_reg <= sat_inc(letter_cnt_reg);
            else            other_cnt_reg  <= sat_inc(other_cnt_reg);
            if (word_inc)   word_cnt_reg   <= sat_inc(word_cnt_reg);
        end
    end

    assign letter_cnt = letter_cnt_reg;
    assign other_cnt  = other_cnt_reg;
    assign word_cnt   = word_cnt_reg;

endmodule

// File: tb/tb_ascii_pos_stream.sv
// Directed bench: scoreboard of expected positions, pops checked as the sink consumes them.
module tb_ascii_pos_stream;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic clr_cnt;
    logic [CNT_W-1:0] letter_cnt, other_cnt, word_cnt;

    int total = 0;
    int bad   = 0;

    logic [5:0] exp_q [$];   // {upper, pos[4:0]}

    ascii_pos_stream_if bus ();

    ascii_pos_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_cnt    (clr_cnt),
        .letter_cnt (letter_cnt),
        .other_cnt  (other_cnt),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] model(input logic [6:0] c, input logic f);
        int v;
        v = int'(c);
        if (v >= 65 && v <= 90)            return {1'b1, 5'(v - 64)};
        if (f && v >= 97 && v <= 122)      return {1'b0, 5'(v - 96)};
        return 6'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    // Present one character and hold it until accepted (bounded wait).
    task automatic push_char(input logic [6:0] c, input logic f);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_ascii = c;
        bus.fold     = f;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            else begin
                n++;
                @(posedge clk);
                #1;
            end
        end
        if (ok) begin
            exp_q.push_back(model(c, f));
            @(posedge clk);
            #1;
        end else begin
            check("accept_timeout", 32'(n), 32'd0);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        tick();
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    // Sink side: every pop is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("pop_pos", 32'(bus.out_pos), 32'(e[4:0]));
                check("pop_upper", 32'(bus.out_upper), 32'(e[5]));
                $display("pop pos=%0d upper=%0d", bus.out_pos, bus.out_upper);
            end
        end
    end

    initial begin
        logic [6:0] s [5];
        rst           = 1'b1;
        clr_cnt       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ascii  = 7'h00;
        bus.fold      = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pos", 32'(bus.out_pos), 32'd0);
        check("rst_out_upper", 32'(bus.out_upper), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_counters", {letter_cnt, other_cnt, word_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic fold=1 encode and single-cycle latency
        bus.out_ready = 1'b1;
        push_char(7'h41, 1'b1);
        check("lat_A_valid", 32'(bus.out_valid), 32'd1);
        push_char(7'h7A, 1'b1);
        check("lat_z_valid", 32'(bus.out_valid), 32'd1);
        drain();
        check("t1_letter", 32'(letter_cnt), 32'd2);
        check("t1_word", 32'(word_cnt), 32'd1);
        check("t1_other", 32'(other_cnt), 32'd0);

        // fold=0: lowercase and range edges are non-letters
        pulse_clr();
        push_char(7'h61, 1'b0);
        push_char(7'h40, 1'b0);
        push_char(7'h5B, 1'b0);
        push_char(7'h5A, 1'b0);
        drain();
        check("t2_letter", 32'(letter_cnt), 32'd1);
        check("t2_other", 32'(other_cnt), 32'd3);
        check("t2_word", 32'(word_cnt), 32'd1);

        // Fill, hold, drain; three rounds walk the pointers past the wrap
        for (int r = 0; r < 3; r++) begin
            pulse_clr();
            bus.out_ready = 1'b0;
            for (int i = 0; i < DEPTH; i++) push_char(7'(8'h41 + i), 1'b1);
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b1;
            bus.in_ascii = 7'h45;
            bus.fold     = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                check("hold_pos", 32'(bus.out_pos), 32'd1);
                check("hold_valid", 32'(bus.out_valid), 32'd1);
            end
            bus.out_ready = 1'b1;
            push_char(7'h45, 1'b1);
            drain();
            check("fill_letter", 32'(letter_cnt), 32'd5);
        end

        // Word counting and clear-vs-accept priority
        pulse_clr();
        s = '{7'h48, 7'h49, 7'h20, 7'h59, 7'h4F};
        for (int i = 0; i < 5; i++) push_char(s[i], 1'b1);
        drain();
        check("t4_word", 32'(word_cnt), 32'd2);
        check("t4_letter", 32'(letter_cnt), 32'd4);
        check("t4_other", 32'(other_cnt), 32'd1);
        clr_cnt = 1'b1;
        push_char(7'h51, 1'b1);
        clr_cnt = 1'b0;
        check("clr_counters", {letter_cnt, other_cnt, word_cnt}, 32'd0);
        push_char(7'h52, 1'b1);
        check("clr_fsm_word", 32'(word_cnt), 32'd1);
        drain();

        // Saturation at 2^CNT_W-1
        pulse_clr();
        for (int i = 0; i < 20; i++) push_char(7'(8'h41 + (i % 26)), 1'b1);
        drain();
        check("sat_letter", 32'(letter_cnt), 32'd15);
        check("sat_word", 32'(word_cnt), 32'd1);

        // Asynchronous reset with entries queued
        bus.out_ready = 1'b0;
        push_char(7'h78, 1'b1);
        push_char(7'h79, 1'b1);
        push_char(7'h21, 1'b1);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_pos", 32'(bus.out_pos), 32'd0);
        check("arst_counters", {letter_cnt, other_cnt, word_cnt}, 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        push_char(7'h6B, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
